// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, class, state and pc_src encodings shared by the sequencer and control_unit
package cpu_pkg;

    localparam logic [3:0] OP_ALU_MAX  = 4'd4;
    localparam logic [3:0] OP_BNE      = 4'd5;
    localparam logic [3:0] OP_LOAD     = 4'd6;
    localparam logic [3:0] OP_STORE    = 4'd7;
    localparam logic [3:0] OP_JUMP     = 4'd8;

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_BNE     = 3'd1;
    localparam logic [2:0] CLS_LOAD    = 3'd2;
    localparam logic [2:0] CLS_STORE   = 3'd3;
    localparam logic [2:0] CLS_JUMP    = 3'd4;
    localparam logic [2:0] CLS_ILLEGAL = 3'd5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_MEM      = 3'd4;
    localparam logic [2:0] ST_WB       = 3'd5;
    localparam logic [2:0] ST_HALT     = 3'd6;

    localparam logic [1:0] PC_NEXT     = 2'b00;
    localparam logic [1:0] PC_BRANCH   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;

    function automatic logic [2:0] op_class(input logic [3:0] op);
        if (op <= OP_ALU_MAX)    return CLS_ALU;
        else if (op == OP_BNE)   return CLS_BNE;
        else if (op == OP_LOAD)  return CLS_LOAD;
        else if (op == OP_STORE) return CLS_STORE;
        else if (op == OP_JUMP)  return CLS_JUMP;
        else                     return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - counts consecutive memory wait cycles and flags expiry at LIMIT
module mem_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    input  logic i_clear,
    output logic o_expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] r_count;

    // Expiry is flagged on the LIMIT-th waiting cycle, so a ready in that cycle clears i_wait and wins.
    assign o_expired = i_wait && (r_count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (i_clear || o_expired) begin
            r_count <= 16'd0;
        end else if (i_wait) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/execute/mem/write-back control FSM
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             illegal_op,
    output logic             mem_err,
    output logic             retire,
    output logic [RET_W-1:0] retired_cnt
);

    logic [2:0]       r_state;
    logic [2:0]       r_class;
    logic             r_mem_err;
    logic [RET_W-1:0] r_retired_cnt;
    logic [2:0]       w_next_state;
    logic [2:0]       w_dec_class;
    logic             w_wait;
    logic             w_expired;

    assign w_dec_class = op_class(opcode);
    assign w_wait      = ((r_state == ST_FETCH) && !imem_ready) ||
                         ((r_state == ST_MEM) && !dmem_ready);
    assign mem_err     = r_mem_err;
    assign retired_cnt = r_retired_cnt;

    mem_watchdog #(.LIMIT(MEM_TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_wait    (w_wait),
        .i_clear   (!w_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_NEXT;
        illegal_op   = 1'b0;
        retire       = 1'b0;
        case (r_state)
            ST_IDLE: w_next_state = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load      = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_expired) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (w_dec_class == CLS_ILLEGAL) begin
                    illegal_op   = 1'b1;
                    pc_write     = 1'b1;
                    retire       = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src = (r_class != CLS_JUMP);
                case (r_class)
                    CLS_ALU:             w_next_state = ST_WB;
                    CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
                    CLS_BNE: begin
                        pc_write     = 1'b1;
                        pc_src       = alu_zero ? PC_NEXT : PC_BRANCH;
                        retire       = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    default: begin
                        pc_write     = 1'b1;
                        pc_src       = PC_JUMP;
                        retire       = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                alu_src  = 1'b1;
                dmem_we  = (r_class == CLS_STORE);
                if (dmem_ready) begin
                    if (r_class == CLS_STORE) begin
                        pc_write     = 1'b1;
                        retire       = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end else if (w_expired) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = (r_class == CLS_LOAD);
                pc_write     = 1'b1;
                retire       = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_class       <= CLS_ALU;
            r_mem_err     <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_class <= w_dec_class;
            end
            if (w_expired) begin
                r_mem_err <= 1'b1;
            end
            if (retire) begin
                r_retired_cnt <= r_retired_cnt + {{(RET_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - table, random and corner-case checks of multicycle_sequencer
module tb_multicycle_sequencer;

    localparam int TMO = 4;
    localparam int RW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    opcode = 4'd0;
    logic          alu_zero = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, ir_load, dmem_req, dmem_we, alu_src, reg_write;
    logic          mem_to_reg, pc_write, illegal_op, mem_err, retire;
    logic [1:0]    pc_src;
    logic [RW-1:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    typedef struct {
        int cycles; int ireq; int irl; int dreq; int dwe; int asrc;
        int rw; int m2r; int pcw; int ill; int pcsrc; int pcw_last;
    } obs_t;

    typedef struct {
        logic [3:0] op; logic az; int idly; int ddly;
        int cycles; int pcsrc; int rw; int m2r; int ill; int dreq;
    } vec_t;

    multicycle_sequencer #(.MEM_TIMEOUT(TMO), .RET_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_src(pc_src), .illegal_op(illegal_op),
        .mem_err(mem_err), .retire(retire), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int strobes();
        return int'({imem_req, ir_load, dmem_req, dmem_we, alu_src, reg_write,
                     mem_to_reg, pc_write, pc_src, illegal_op, retire});
    endfunction

    // Reference: instruction shape follows from its class and the two ready delays.
    function automatic obs_t model(input logic [3:0] op, input logic az, input int idly, input int ddly);
        obs_t e;
        bit is_alu, is_bne, is_ld, is_st, is_jmp, is_ill;
        is_alu = (op <= 4); is_bne = (op == 5); is_ld = (op == 6);
        is_st = (op == 7); is_jmp = (op == 8); is_ill = (op >= 9);
        e.ireq = idly + 1; e.irl = 1; e.pcw = 1; e.pcw_last = 1;
        if (is_alu)             e.cycles = idly + 4;
        else if (is_ld)         e.cycles = idly + ddly + 5;
        else if (is_st)         e.cycles = idly + ddly + 4;
        else if (is_bne || is_jmp) e.cycles = idly + 3;
        else                    e.cycles = idly + 2;
        e.dreq  = (is_ld || is_st) ? ddly + 1 : 0;
        e.dwe   = is_st ? ddly + 1 : 0;
        e.asrc  = (is_alu || is_bne) ? 1 : ((is_ld || is_st) ? ddly + 2 : 0);
        e.rw    = (is_alu || is_ld) ? 1 : 0;
        e.m2r   = is_ld ? 1 : 0;
        e.ill   = is_ill ? 1 : 0;
        e.pcsrc = is_jmp ? 2 : ((is_bne && !az) ? 1 : 0);
        return e;
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic az, input int idly,
                             input int ddly, output obs_t o);
        int iw = 0;
        int dw = 0;
        bit done = 0;
        o = '{default: 0};
        opcode = op;
        alu_zero = az;
        while (!done && o.cycles < 40) begin
            @(negedge clk);
            imem_ready = imem_req ? (iw == idly) : 1'($urandom % 2);
            dmem_ready = dmem_req ? (dw == ddly) : 1'($urandom % 2);
            #1;
            o.cycles++;
            if (imem_req) begin o.ireq++; if (!imem_ready) iw++; end
            if (dmem_req) begin o.dreq++; if (!dmem_ready) dw++; end
            o.irl  += int'(ir_load);
            o.dwe  += int'(dmem_we);
            o.asrc += int'(alu_src);
            o.rw   += int'(reg_write);
            o.m2r  += int'(mem_to_reg);
            o.pcw  += int'(pc_write);
            o.ill  += int'(illegal_op);
            if (retire) begin
                done = 1;
                o.pcsrc = int'(pc_src);
                o.pcw_last = int'(pc_write);
            end
        end
        chk("instr_completes", int'(done), 1);
        @(posedge clk);
        #1;
        exp_ret = (exp_ret + 1) % (1 << RW);
        chk("retired_cnt", int'(retired_cnt), exp_ret);
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".cycles"}, a.cycles, e.cycles);
        chk({tag, ".imem_req"}, a.ireq, e.ireq);
        chk({tag, ".ir_load"}, a.irl, e.irl);
        chk({tag, ".dmem_req"}, a.dreq, e.dreq);
        chk({tag, ".dmem_we"}, a.dwe, e.dwe);
        chk({tag, ".alu_src"}, a.asrc, e.asrc);
        chk({tag, ".reg_write"}, a.rw, e.rw);
        chk({tag, ".mem_to_reg"}, a.m2r, e.m2r);
        chk({tag, ".pc_write"}, a.pcw, e.pcw);
        chk({tag, ".pc_write_last"}, a.pcw_last, e.pcw_last);
        chk({tag, ".illegal_op"}, a.ill, e.ill);
        chk({tag, ".pc_src"}, a.pcsrc, e.pcsrc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_strobes", strobes(), 0);
        chk("reset_mem_err", int'(mem_err), 0);
        chk("reset_retired_cnt", int'(retired_cnt), 0);
        rst = 1'b0;
        #1;
        chk("idle_strobes", strobes(), 0);
        exp_ret = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic ir, input logic dr);
        @(negedge clk);
        imem_ready = ir;
        dmem_ready = dr;
        #1;
    endtask

    vec_t vecs[8];
    obs_t got;
    obs_t exp_o;
    int   cnt;
    int   bad;

    initial begin
        vecs[0] = '{4'd2,  1'b0, 0, 0, 4, 0, 1, 0, 0, 0};
        vecs[1] = '{4'd6,  1'b0, 0, 3, 8, 0, 1, 1, 0, 4};
        vecs[2] = '{4'd5,  1'b0, 0, 0, 3, 1, 0, 0, 0, 0};
        vecs[3] = '{4'd5,  1'b1, 0, 0, 3, 0, 0, 0, 0, 0};
        vecs[4] = '{4'd8,  1'b0, 0, 0, 3, 2, 0, 0, 0, 0};
        vecs[5] = '{4'd12, 1'b0, 0, 0, 2, 0, 0, 0, 1, 0};
        vecs[6] = '{4'd7,  1'b0, 0, 0, 4, 0, 0, 0, 0, 1};
        vecs[7] = '{4'd0,  1'b1, 3, 0, 7, 0, 1, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i].op, vecs[i].az, vecs[i].idly, vecs[i].ddly, got);
            chk($sformatf("vec%0d.cycles", i), got.cycles, vecs[i].cycles);
            chk($sformatf("vec%0d.pc_src", i), got.pcsrc, vecs[i].pcsrc);
            chk($sformatf("vec%0d.reg_write", i), got.rw, vecs[i].rw);
            chk($sformatf("vec%0d.mem_to_reg", i), got.m2r, vecs[i].m2r);
            chk($sformatf("vec%0d.illegal_op", i), got.ill, vecs[i].ill);
            chk($sformatf("vec%0d.dmem_req", i), got.dreq, vecs[i].dreq);
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            logic az;
            int idly;
            int ddly;
            op = 4'($urandom % 16);
            az = 1'($urandom % 2);
            idly = int'($urandom % TMO);
            ddly = int'($urandom % TMO);
            run_instr(op, az, idly, ddly, got);
            exp_o = model(op, az, idly, ddly);
            cmp_obs($sformatf("rnd%0d", i), got, exp_o);
        end
        chk("wrap_to_zero", int'(retired_cnt), 0);
        for (int i = 16; i < 60; i++) begin
            logic [3:0] op;
            logic az;
            int idly;
            int ddly;
            op = 4'($urandom % 16);
            az = 1'($urandom % 2);
            idly = int'($urandom % TMO);
            ddly = int'($urandom % TMO);
            run_instr(op, az, idly, ddly, got);
            exp_o = model(op, az, idly, ddly);
            cmp_obs($sformatf("rnd%0d", i), got, exp_o);
        end

        do_reset();
        cnt = 0;
        for (int i = 0; i < 12 && !mem_err; i++) begin
            step(1'b0, 1'b0);
            if (imem_req) cnt++;
        end
        chk("timeout_wait_cycles", cnt, TMO);
        chk("timeout_mem_err", int'(mem_err), 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom % 2), 1'($urandom % 2));
            if (strobes() != 0 || !mem_err) bad++;
        end
        chk("halt_held", bad, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_mem_err", int'(mem_err), 0);
        do_reset();

        run_instr(4'd1, 1'b0, 0, 0, got);
        run_instr(4'd3, 1'b0, 0, 0, got);
        opcode = 4'd7;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("store_mem_req", int'(dmem_req), 1);
        chk("store_mem_we", int'(dmem_we), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", int'(dmem_req), 0);
        chk("rst_mid_mem_we", int'(dmem_we), 0);
        chk("rst_mid_retired", int'(retired_cnt), 0);
        do_reset();
        chk("resume_fetch", int'(imem_req), 1);
        run_instr(4'd4, 1'b0, 0, 0, got);
        exp_o = model(4'd4, 1'b0, 0, 0);
        cmp_obs("resume", got, exp_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
